// File: rtl/riscv_if_pqueue.sv
// Instruction-fetch parcel queue: buffers fetched parcels as halfwords and issues realigned
// 16/32-bit instructions to ID, one per cycle. Define RISCV_IF_RVC_EN to issue compressed instructions.
module riscv_if_pqueue #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] PC_INIT        = 'h200,
    parameter int unsigned     PARCEL_SIZE    = 32,
    parameter int unsigned     QUEUE_DEPTH    = 8,
    parameter int unsigned     ILEN           = 32,
    parameter int unsigned     EXCEPTION_SIZE = 16
) (
    input  logic                      rstn,
    input  logic                      clk,
    input  logic                      id_stall,
    input  logic                      if_stall_nxt_pc,
    input  logic [PARCEL_SIZE-1:0]    if_parcel,
    input  logic [XLEN-1:0]           if_parcel_pc,
    input  logic                      if_parcel_valid,
    input  logic                      if_parcel_misaligned,
    input  logic                      if_parcel_page_fault,
    input  logic                      bu_flush,
    input  logic                      st_flush,
    input  logic                      du_flush,
    input  logic [XLEN-1:0]           bu_nxt_pc,
    input  logic [XLEN-1:0]           st_nxt_pc,
    output logic [XLEN-1:0]           if_nxt_pc,
    output logic                      if_stall,
    output logic                      if_flush,
    output logic [ILEN-1:0]           if_instr,
    output logic                      if_instr_rvc,
    output logic [XLEN-1:0]           if_pc,
    output logic                      if_bubble,
    output logic [EXCEPTION_SIZE-1:0] if_exception
);

    localparam int unsigned PHW    = PARCEL_SIZE / 16;
    localparam int unsigned PBYTES = PARCEL_SIZE / 8;
    localparam int unsigned PTRW   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNTW   = PTRW + 1;
    localparam int unsigned DW     = $clog2(PHW);

    localparam int unsigned     CAUSE_MISALIGNED_INSTRUCTION   = 0;
    localparam int unsigned     CAUSE_INSTRUCTION_ACCESS_FAULT = 1;
    localparam logic [ILEN-1:0] INSTR_NOP                      = ILEN'(32'h0000_0013);
    localparam logic [ILEN-1:0] INSTR_ILLEGAL                  = '1;

    // Halfword queue storage
    logic [15:0]            hw_q  [QUEUE_DEPTH];
    logic [15:0]            hw_d  [QUEUE_DEPTH];
    logic [XLEN-1:0]        hpc_q [QUEUE_DEPTH];
    logic [XLEN-1:0]        hpc_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] mis_q, mis_d;
    logic [QUEUE_DEPTH-1:0] flt_q, flt_d;

    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [DW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0]           nxt_pc_q, nxt_pc_d;
    logic [ILEN-1:0]           instr_q, instr_d;
    logic                      rvc_q, rvc_d;
    logic [XLEN-1:0]           ipc_q, ipc_d;
    logic                      bubble_q, bubble_d;
    logic [EXCEPTION_SIZE-1:0] exc_q, exc_d;

    logic            flush;
    logic [XLEN-1:0] flush_tgt;
    logic [CNTW-1:0] free;
    logic [PTRW-1:0] rd_nxt;
    logic [15:0]     h0, h1;

    logic            dec_rdy;
    logic [ILEN-1:0] dec_instr;
    logic            dec_rvc;
    logic [CNTW-1:0] dec_pop;
    logic            dec_mis, dec_flt;

    logic [PTRW-1:0] widx;
    logic [CNTW-1:0] push_n;

    assign flush     = bu_flush | st_flush | du_flush;
    assign flush_tgt = st_flush ? st_nxt_pc : bu_nxt_pc;
    assign free      = CNTW'(QUEUE_DEPTH) - count_q;
    assign if_stall  = id_stall | (free < CNTW'(PHW));
    assign if_flush  = flush;

    assign rd_nxt = rd_ptr_q + PTRW'(1);
    assign h0     = hw_q[rd_ptr_q];
    assign h1     = hw_q[rd_nxt];

    // Decode the head of the queue into the next issuable instruction
    always_comb begin
        dec_rdy   = 1'b0;
        dec_instr = INSTR_NOP;
        dec_rvc   = 1'b0;
        dec_pop   = '0;
        dec_mis   = 1'b0;
        dec_flt   = 1'b0;
        if (count_q != '0) begin
            if (h0[1:0] == 2'b11) begin
                if (count_q >= CNTW'(2)) begin
                    dec_rdy   = 1'b1;
                    dec_instr = ILEN'({h1, h0});
                    dec_pop   = CNTW'(2);
                    dec_mis   = mis_q[rd_ptr_q] | mis_q[rd_nxt];
                    dec_flt   = flt_q[rd_ptr_q] | flt_q[rd_nxt];
                end
            end else begin
                dec_rdy = 1'b1;
                dec_pop = CNTW'(1);
                dec_mis = mis_q[rd_ptr_q];
                dec_flt = flt_q[rd_ptr_q];
`ifdef RISCV_IF_RVC_EN
                dec_instr = ILEN'({16'h0000, h0});
                dec_rvc   = 1'b1;
`else
                dec_instr = INSTR_ILLEGAL;
`endif
            end
        end
    end

    // Queue push/pop, fetch address and output register next-state
    always_comb begin
        hw_d     = hw_q;
        hpc_d    = hpc_q;
        mis_d    = mis_q;
        flt_d    = flt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        nxt_pc_d = nxt_pc_q;
        instr_d  = instr_q;
        rvc_d    = rvc_q;
        ipc_d    = ipc_q;
        bubble_d = bubble_q;
        exc_d    = exc_q;
        widx     = wr_ptr_q;
        push_n   = '0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = flush_tgt[DW:1];
            nxt_pc_d = flush_tgt;
            instr_d  = INSTR_NOP;
            rvc_d    = 1'b0;
            ipc_d    = flush_tgt;
            bubble_d = 1'b1;
            exc_d    = '0;
        end else begin
            if (!id_stall) begin
                exc_d = '0;
                if (dec_rdy) begin
                    instr_d  = dec_instr;
                    rvc_d    = dec_rvc;
                    ipc_d    = hpc_q[rd_ptr_q];
                    bubble_d = 1'b0;
                    exc_d[CAUSE_MISALIGNED_INSTRUCTION]   = dec_mis;
                    exc_d[CAUSE_INSTRUCTION_ACCESS_FAULT] = dec_flt;
                end else begin
                    instr_d  = INSTR_NOP;
                    rvc_d    = 1'b0;
                    bubble_d = 1'b1;
                end
            end

            // Halfwords below the fetch target inside the first parcel are skipped
            if (if_parcel_valid) begin
                for (int i = 0; i < int'(PHW); i++) begin
                    if (i >= int'(drop_q)) begin
                        hw_d[widx]  = if_parcel[16*i +: 16];
                        hpc_d[widx] = if_parcel_pc + XLEN'(2 * i);
                        mis_d[widx] = if_parcel_misaligned;
                        flt_d[widx] = if_parcel_page_fault;
                        widx        = widx + PTRW'(1);
                        push_n      = push_n + CNTW'(1);
                    end
                end
                drop_d = '0;
            end

            rd_ptr_d = rd_ptr_q + PTRW'((id_stall || !dec_rdy) ? CNTW'(0) : dec_pop);
            wr_ptr_d = widx;
            count_d  = count_q + push_n - ((id_stall || !dec_rdy) ? CNTW'(0) : dec_pop);

            if (!if_stall_nxt_pc && !if_stall) begin
                nxt_pc_d = (nxt_pc_q & ~XLEN'(PBYTES - 1)) + XLEN'(PBYTES);
            end
        end
    end

    // Queue payload needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        hw_q  <= hw_d;
        hpc_q <= hpc_d;
        mis_q <= mis_d;
        flt_q <= flt_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= PC_INIT[DW:1];
            nxt_pc_q <= PC_INIT;
            instr_q  <= INSTR_NOP;
            rvc_q    <= 1'b0;
            ipc_q    <= PC_INIT;
            bubble_q <= 1'b1;
            exc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            nxt_pc_q <= nxt_pc_d;
            instr_q  <= instr_d;
            rvc_q    <= rvc_d;
            ipc_q    <= ipc_d;
            bubble_q <= bubble_d;
            exc_q    <= exc_d;
        end
    end

    assign if_nxt_pc    = nxt_pc_q;
    assign if_instr     = instr_q;
    assign if_instr_rvc = rvc_q;
    assign if_pc        = ipc_q;
    assign if_bubble    = bubble_q;
    assign if_exception = exc_q;

endmodule

// File: tb/tb_riscv_if_pqueue.sv
// Randomized bench for riscv_if_pqueue against a halfword-queue reference model,
// plus directed fetch, flush, stall-fill, fault and compressed/illegal scenarios.
module tb_riscv_if_pqueue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PSIZE = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PHW   = PSIZE / 16;
    localparam int unsigned PB    = PSIZE / 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             rstn, clk;
    logic             id_stall, if_stall_nxt_pc;
    logic [PSIZE-1:0] if_parcel;
    logic [XLEN-1:0]  if_parcel_pc;
    logic             if_parcel_valid, if_parcel_misaligned, if_parcel_page_fault;
    logic             bu_flush, st_flush, du_flush;
    logic [XLEN-1:0]  bu_nxt_pc, st_nxt_pc;
    logic [XLEN-1:0]  if_nxt_pc, if_pc;
    logic             if_stall, if_flush, if_instr_rvc, if_bubble;
    logic [31:0]      if_instr;
    logic [15:0]      if_exception;

    riscv_if_pqueue #(.XLEN(XLEN), .PC_INIT('h200), .PARCEL_SIZE(PSIZE), .QUEUE_DEPTH(DEPTH)) dut (
        .rstn(rstn), .clk(clk), .id_stall(id_stall), .if_stall_nxt_pc(if_stall_nxt_pc),
        .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc), .if_parcel_valid(if_parcel_valid),
        .if_parcel_misaligned(if_parcel_misaligned), .if_parcel_page_fault(if_parcel_page_fault),
        .bu_flush(bu_flush), .st_flush(st_flush), .du_flush(du_flush),
        .bu_nxt_pc(bu_nxt_pc), .st_nxt_pc(st_nxt_pc), .if_nxt_pc(if_nxt_pc), .if_stall(if_stall),
        .if_flush(if_flush), .if_instr(if_instr), .if_instr_rvc(if_instr_rvc), .if_pc(if_pc),
        .if_bubble(if_bubble), .if_exception(if_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
        logic        mis;
        logic        flt;
    } hw_t;

    hw_t         mq[$];
    logic [31:0] m_nxt_pc, m_instr, m_pc;
    logic        m_rvc, m_bubble;
    logic [15:0] m_exc;
    int          m_drop;
    logic [31:0] f_pc;
    bit          chk_en;
    int          n_chk, n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour for one clock edge, from the current inputs
    task automatic model_step();
        bit          flush, stall;
        logic [31:0] tgt;
        flush = bu_flush | st_flush | du_flush;
        stall = id_stall || (int'(DEPTH) - mq.size() < int'(PHW));
        if (flush) begin
            tgt      = st_flush ? st_nxt_pc : bu_nxt_pc;
            mq.delete();
            m_nxt_pc = tgt;
            m_drop   = int'((tgt >> 1) % PHW);
            m_bubble = 1'b1;
            m_instr  = NOP;
            m_rvc    = 1'b0;
            m_exc    = '0;
            m_pc     = tgt;
            f_pc     = (tgt / PB) * PB;
            return;
        end
        if (!id_stall) begin
            m_exc = '0;
            if (mq.size() >= 1 && mq[0].hw[1:0] != 2'b11) begin
`ifdef RISCV_IF_RVC_EN
                m_instr = {16'h0, mq[0].hw};
                m_rvc   = 1'b1;
`else
                m_instr = 32'hFFFF_FFFF;
                m_rvc   = 1'b0;
`endif
                m_pc     = mq[0].pc;
                m_bubble = 1'b0;
                m_exc    = 16'(mq[0].mis) | (16'(mq[0].flt) << 1);
                void'(mq.pop_front());
            end else if (mq.size() >= 2) begin
                m_instr  = {mq[1].hw, mq[0].hw};
                m_rvc    = 1'b0;
                m_pc     = mq[0].pc;
                m_bubble = 1'b0;
                m_exc    = 16'(mq[0].mis | mq[1].mis) | (16'(mq[0].flt | mq[1].flt) << 1);
                void'(mq.pop_front());
                void'(mq.pop_front());
            end else begin
                m_instr  = NOP;
                m_rvc    = 1'b0;
                m_bubble = 1'b1;
            end
        end
        if (if_parcel_valid) begin
            for (int i = m_drop; i < int'(PHW); i++) begin
                hw_t e;
                e.hw  = if_parcel[16*i +: 16];
                e.pc  = if_parcel_pc + 32'(2 * i);
                e.mis = if_parcel_misaligned;
                e.flt = if_parcel_page_fault;
                mq.push_back(e);
            end
            m_drop = 0;
            f_pc   = f_pc + PB;
        end
        if (!if_stall_nxt_pc && !stall) m_nxt_pc = (m_nxt_pc / PB) * PB + PB;
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("nxt_pc", 64'(if_nxt_pc), 64'(m_nxt_pc));
            check("stall", 64'(if_stall), 64'(id_stall || (int'(DEPTH) - mq.size() < int'(PHW))));
            check("flush", 64'(if_flush), 64'(bu_flush | st_flush | du_flush));
            check("bubble", 64'(if_bubble), 64'(m_bubble));
            check("instr", 64'(if_instr), 64'(m_instr));
            check("rvc", 64'(if_instr_rvc), 64'(m_rvc));
            check("pc", 64'(if_pc), 64'(m_pc));
            check("exc", 64'(if_exception), 64'(m_exc));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        id_stall = 0; if_stall_nxt_pc = 0; if_parcel_valid = 0; if_parcel = '0;
        if_parcel_pc = '0; if_parcel_misaligned = 0; if_parcel_page_fault = 0;
        bu_flush = 0; st_flush = 0; du_flush = 0;
    endtask

    task automatic parcel(input logic [31:0] d, input logic [31:0] pc, input logic flt);
        idle();
        if_parcel_valid = 1; if_parcel = d; if_parcel_pc = pc; if_parcel_page_fault = flt;
    endtask

    task automatic bflush(input logic [31:0] tgt);
        idle();
        bu_flush = 1; bu_nxt_pc = tgt;
    endtask

    task automatic drive_random();
        int r;
        logic [15:0] h0, h1;
        id_stall        = ($urandom % 100) < 30;
        if_stall_nxt_pc = ($urandom % 100) < 20;
        r = int'($urandom % 100);
        bu_flush  = r < 3 || r == 7;
        st_flush  = (r >= 3 && r < 5) || r == 7;
        du_flush  = r == 5;
        bu_nxt_pc = 32'h1000 + 32'($urandom % 256) * 2;
        st_nxt_pc = 32'h2000 + 32'($urandom % 256) * 2;
        h0 = 16'($urandom); h1 = 16'($urandom);
        if ($urandom % 2 == 0) h0[1:0] = 2'b11;
        if ($urandom % 2 == 0) h1[1:0] = 2'b11;
        if_parcel            = {h1, h0};
        if_parcel_pc         = f_pc;
        if_parcel_valid      = (int'(DEPTH) - mq.size() >= int'(PHW)) && (($urandom % 100) < 60);
        if_parcel_misaligned = ($urandom % 20) == 0;
        if_parcel_page_fault = ($urandom % 20) == 0;
    endtask

    logic [31:0] exp16a, exp16b;

    initial begin
        n_chk = 0; n_pass = 0; chk_en = 0;
        rstn = 0; bu_nxt_pc = '0; st_nxt_pc = '0;
        idle();
        m_nxt_pc = 32'h200; m_pc = 32'h200; m_instr = NOP; m_rvc = 0; m_bubble = 1;
        m_exc = '0; m_drop = 0; f_pc = 32'h200;
`ifdef RISCV_IF_RVC_EN
        exp16a = 32'h0000_0001; exp16b = 32'h0000_4501;
`else
        exp16a = 32'hFFFF_FFFF; exp16b = 32'hFFFF_FFFF;
`endif
        #12 rstn = 1;
        #1;
        chk_en = 1;
        check("rst_nxt_pc", 64'(if_nxt_pc), 64'h200);
        check("rst_pc", 64'(if_pc), 64'h200);
        check("rst_instr", 64'(if_instr), 64'(NOP));
        check("rst_bubble", 64'(if_bubble), 64'd1);
        check("rst_exc", 64'(if_exception), 64'd0);

        // Straight-line 32-bit fetch
        parcel(32'h0000_0013, 32'h200, 0); step();
        check("f1_nxt_pc", 64'(if_nxt_pc), 64'h204);
        check("f1_bubble", 64'(if_bubble), 64'd1);
        parcel(32'h0000_0013, 32'h204, 0); step();
        check("f2_instr", 64'(if_instr), 64'h13);
        check("f2_pc", 64'(if_pc), 64'h200);
        check("f2_bubble", 64'(if_bubble), 64'd0);
        idle(); step();
        check("f3_pc", 64'(if_pc), 64'h204);
        idle(); step();
        check("f4_bubble", 64'(if_bubble), 64'd1);
        check("f4_pc_held", 64'(if_pc), 64'h204);

        // Flush to a halfword-offset target drops the low halfword
        bflush(32'h302); step();
        check("fl_pc", 64'(if_pc), 64'h302);
        check("fl_bubble", 64'(if_bubble), 64'd1);
        check("fl_nxt_pc", 64'(if_nxt_pc), 64'h302);
        parcel(32'h4501_AAAA, 32'h300, 0); step();
        idle(); step();
        check("fl_first_pc", 64'(if_pc), 64'h302);
        check("fl_first_instr", 64'(if_instr), 64'(exp16b));

        // Compressed pair followed by a 32-bit instruction
        bflush(32'h200); step();
        parcel(32'h4501_0001, 32'h200, 0); step();
        parcel(32'h0000_0513, 32'h204, 0); step();
        check("c0_instr", 64'(if_instr), 64'(exp16a));
        check("c0_pc", 64'(if_pc), 64'h200);
        idle(); step();
        check("c1_instr", 64'(if_instr), 64'(exp16b));
        check("c1_pc", 64'(if_pc), 64'h202);
        idle(); step();
        check("c2_instr", 64'(if_instr), 64'h513);
        check("c2_pc", 64'(if_pc), 64'h204);
        check("c2_rvc", 64'(if_instr_rvc), 64'd0);

        // Access fault tagged onto the instruction, then cleared by st+bu flush
        bflush(32'h400); step();
        parcel(32'h0000_0013, 32'h400, 1); step();
        idle(); step();
        check("pf_pc", 64'(if_pc), 64'h400);
        check("pf_exc", 64'(if_exception), 64'h2);
        idle(); st_flush = 1; st_nxt_pc = 32'h500; bu_flush = 1; bu_nxt_pc = 32'h600; step();
        check("sb_nxt_pc", 64'(if_nxt_pc), 64'h500);
        check("sb_exc", 64'(if_exception), 64'd0);
        check("sb_pc", 64'(if_pc), 64'h500);

        // ID stall while the BIU streams fills the queue
        for (int i = 0; i < 6; i++) begin
            if (i < 4) parcel(32'h0000_0013 | (32'(i) << 7), 32'h500 + 32'(4 * i), 0);
            else idle();
            id_stall = 1;
            step();
        end
        idle(); #1;
        check("full_stall", 64'(if_stall), 64'd1);
        step();
        check("full_rel_pc", 64'(if_pc), 64'h500);
        for (int i = 0; i < 5; i++) begin idle(); step(); end
        check("full_last_pc", 64'(if_pc), 64'h50C);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            step();
        end

        idle();
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
